// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter and the
// synchronizer that the keyboard receiver can also reuse.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SEND,
      WAIT_IDLE
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_NOACK   = 2'b01,
      ERR_TIMEOUT = 2'b10
   } err_t;

   // Device falling edge on which the acknowledge bit is sampled.
   localparam logic [3:0] LAST_BIT = 4'd11;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data pins, plus a falling-edge
// detect on the synchronized clock.
module ps2_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic ps2_clk_i,
   input  logic ps2_dat_i,
   output logic clk_sync_o,
   output logic dat_sync_o,
   output logic fall_o
);

   logic clk_s1_q, clk_s2_q, clk_s3_q;
   logic dat_s1_q, dat_s2_q;

   // Reset to the idle (released, pulled-up) level so no false edge follows reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         clk_s3_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= ps2_clk_i;
         clk_s2_q <= clk_s1_q;
         clk_s3_q <= clk_s2_q;
         dat_s1_q <= ps2_dat_i;
         dat_s2_q <= dat_s1_q;
      end
   end

   assign clk_sync_o = clk_s2_q;
   assign dat_sync_o = dat_s2_q;
   assign fall_o     = clk_s3_q & ~clk_s2_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts
// one byte out on device clock falls and checks the device acknowledge.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int SETUP_CYCLES   = 100,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic [1:0] err
);

   localparam int MAX_A = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
   localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
   localparam int CW    = $clog2(MAX_C) + 1;

   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] SET_LAST = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

   logic clk_sync, dat_sync, fall;

   ps2_sync_edge u_sync (
      .clk_i      (Clk),
      .rst_i      (reset),
      .ps2_clk_i  (ps2_clk_in),
      .ps2_dat_i  (ps2_dat_in),
      .clk_sync_o (clk_sync),
      .dat_sync_o (dat_sync),
      .fall_o     (fall)
   );

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [3:0]    bitcnt_q;
   logic [7:0]    data_q;
   logic          parity_q;
   logic          clk_oe_q, dat_oe_q, busy_q, done_q;
   err_t          err_q, ack_err_q;

   // Request/response: tx_start is a one-cycle request taken only in IDLE;
   // done is a one-cycle response, err is valid with it and held until the next.
   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bitcnt_q  <= '0;
         data_q    <= '0;
         parity_q  <= 1'b0;
         clk_oe_q  <= 1'b0;
         dat_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= ERR_OK;
         ack_err_q <= ERR_OK;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (tx_start) begin
                  data_q   <= tx_data;
                  parity_q <= odd_parity(tx_data);
                  cnt_q    <= '0;
                  clk_oe_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= INHIBIT;
               end
            end
            INHIBIT: begin
               if (cnt_q == INH_LAST) begin
                  cnt_q    <= '0;
                  dat_oe_q <= 1'b1;
                  state_q  <= REQ;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            REQ: begin
               if (cnt_q == SET_LAST) begin
                  clk_oe_q <= 1'b0;
                  cnt_q    <= '0;
                  bitcnt_q <= '0;
                  state_q  <= SEND;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            SEND: begin
               if (fall) begin
                  cnt_q    <= '0;
                  bitcnt_q <= bitcnt_q + 4'd1;
                  // bitcnt_q still holds the count before this fall.
                  if (bitcnt_q < 4'd8) begin
                     dat_oe_q <= ~data_q[bitcnt_q[2:0]];
                  end else if (bitcnt_q == 4'd8) begin
                     dat_oe_q <= ~parity_q;
                  end else if (bitcnt_q == 4'd9) begin
                     dat_oe_q <= 1'b0;
                  end else if (bitcnt_q == LAST_BIT - 4'd1) begin
                     ack_err_q <= dat_sync ? ERR_NOACK : ERR_OK;
                     state_q   <= WAIT_IDLE;
                  end
               end else if (cnt_q == TO_LAST) begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  err_q    <= ERR_TIMEOUT;
                  cnt_q    <= '0;
                  state_q  <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            WAIT_IDLE: begin
               if (clk_sync && dat_sync) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  err_q   <= ack_err_q;
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if (cnt_q == TO_LAST) begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  err_q    <= ERR_TIMEOUT;
                  cnt_q    <= '0;
                  state_q  <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               clk_oe_q <= 1'b0;
               dat_oe_q <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on wired-AND lines
// and queues of expected frame bits and completion status.
module tb_ps2_host_tx;

   localparam int INH  = 5000;
   localparam int SET  = 100;
   localparam int TO   = 3000;
   localparam int HALF = 40;

   logic       Clk = 1'b0;
   logic       reset;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       ps2_clk_oe, ps2_dat_oe, busy, done;
   logic [1:0] err;
   logic       dev_clk, dev_dat;
   logic       kbclk, kbdat;

   int         n_cmp = 0;
   int         n_err = 0;
   int         done_cnt = 0;
   logic [1:0] last_err = 2'b00;
   logic [9:0] exp_q[$];
   logic [1:0] exp_err_q[$];

   assign kbclk = ~ps2_clk_oe & dev_clk;
   assign kbdat = ~ps2_dat_oe & dev_dat;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .SETUP_CYCLES   (SET),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .Clk        (Clk),
      .reset      (reset),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .ps2_clk_in (kbclk),
      .ps2_dat_in (kbdat),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      if (done === 1'b1) begin
         done_cnt = done_cnt + 1;
         last_err = err;
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_parity(input logic [7:0] d);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return (ones % 2 == 0) ? 1'b1 : 1'b0;
   endfunction

   task automatic measure_low(output int low_cyc, output int dat_at);
      low_cyc = 0;
      dat_at  = -1;
      while (ps2_clk_oe === 1'b1 && low_cyc < INH + SET + 100) begin
         if (ps2_dat_oe === 1'b1 && dat_at < 0) dat_at = low_cyc;
         low_cyc++;
         tick();
      end
   endtask

   task automatic device_frame(input int nfalls, input bit ack, input int inject_fall,
                               input int reset_fall, output logic [9:0] bits);
      int k = 0;
      bits = '0;
      while (ps2_clk_oe !== 1'b0 && k < INH + SET + 100) begin
         tick();
         k++;
      end
      check("start_bit", 32'(kbdat), 32'd0);
      repeat (10) tick();
      for (int i = 1; i <= nfalls; i++) begin
         if (i == 11 && ack) dev_dat = 1'b0;
         dev_clk = 1'b0;
         repeat (HALF / 2) tick();
         if (i == inject_fall) begin
            tx_data  = 8'h55;
            tx_start = 1'b1;
            tick();
            tx_start = 1'b0;
         end
         if (i == reset_fall) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
            check("reset_dat_oe", 32'(ps2_dat_oe), 32'd0);
            check("reset_busy", 32'(busy), 32'd0);
            dev_clk = 1'b1;
            break;
         end
         repeat (HALF / 2) tick();
         if (i <= 10) bits[i-1] = kbdat;
         dev_clk = 1'b1;
         repeat (HALF) tick();
      end
      dev_dat = 1'b1;
   endtask

   task automatic wait_done(input int target);
      int k = 0;
      while (done_cnt < target && k < 20000) begin
         tick();
         k++;
      end
      check("done_seen", 32'(done_cnt >= target), 32'd1);
   endtask

   task automatic run_frame(input logic [7:0] d, input bit ack, input int inject_fall,
                            input int reset_fall, input logic [1:0] exp_err);
      int         base, low_cyc, dat_at;
      logic [9:0] bits, e_bits;
      logic [1:0] e_err;
      base = done_cnt;
      if (reset_fall == 0) begin
         exp_q.push_back({1'b1, model_parity(d), d});
         exp_err_q.push_back(exp_err);
      end
      tx_data  = d;
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("clk_oe_after_start", 32'(ps2_clk_oe), 32'd1);
      fork
         measure_low(low_cyc, dat_at);
         device_frame(11, ack, inject_fall, reset_fall, bits);
      join
      check("clk_low_cycles", 32'(low_cyc), 32'(INH + SET));
      check("data_low_start", 32'(dat_at), 32'(INH));
      if (reset_fall == 0) begin
         e_bits = exp_q.pop_front();
         check("frame_bits", 32'(bits), 32'(e_bits));
         wait_done(base + 1);
         e_err = exp_err_q.pop_front();
         check("done_err", 32'(last_err), 32'(e_err));
         check("end_clk_oe", 32'(ps2_clk_oe), 32'd0);
         check("end_dat_oe", 32'(ps2_dat_oe), 32'd0);
         check("end_busy", 32'(busy), 32'd0);
         repeat (50) tick();
         check("single_done", 32'(done_cnt), 32'(base + 1));
      end else begin
         repeat (200) tick();
         check("no_done_on_reset", 32'(done_cnt), 32'(base));
         check("idle_after_reset", 32'(busy), 32'd0);
      end
   endtask

   task automatic run_timeout(input logic [7:0] d);
      int         low_cyc, dat_at, k;
      logic [1:0] e_err;
      exp_err_q.push_back(2'b10);
      tx_data  = d;
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
      measure_low(low_cyc, dat_at);
      check("to_clk_low_cycles", 32'(low_cyc), 32'(INH + SET));
      k = 0;
      while (done !== 1'b1 && k < TO + 100) begin
         tick();
         k++;
      end
      check("timeout_latency", 32'(k), 32'(TO));
      e_err = exp_err_q.pop_front();
      check("timeout_err", 32'(err), 32'(e_err));
      check("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("timeout_dat_oe", 32'(ps2_dat_oe), 32'd0);
      check("timeout_busy", 32'(busy), 32'd0);
      repeat (50) tick();
   endtask

   initial begin
      reset    = 1'b1;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      dev_clk  = 1'b1;
      dev_dat  = 1'b1;
      repeat (5) tick();
      reset = 1'b0;
      tick();
      check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);

      run_frame(8'hED, 1'b1, 0, 0, 2'b00);
      run_frame(8'hF4, 1'b1, 0, 0, 2'b00);
      run_frame(8'hFF, 1'b0, 0, 0, 2'b01);
      run_timeout(8'h00);
      run_frame(8'hED, 1'b1, 3, 0, 2'b00);
      run_frame(8'hA5, 1'b1, 0, 5, 2'b00);
      run_frame(8'hF4, 1'b1, 0, 0, 2'b00);
      run_frame(8'($urandom_range(0, 255)), 1'b1, 0, 0, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
